// File: rtl/instr_store_pkg.sv
// Shared constants for the runtime-loadable instruction store.
package instr_store_pkg;

  localparam logic [31:0] STOP_INSTR  = 32'h0000_0006;
  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_SLVERR = 2'b10;

  localparam logic [1:0] W_IDLE   = 2'd0;
  localparam logic [1:0] W_COMMIT = 2'd1;
  localparam logic [1:0] W_RESP   = 2'd2;

  localparam logic [1:0] R_IDLE = 2'd0;
  localparam logic [1:0] R_READ = 2'd1;
  localparam logic [1:0] R_RESP = 2'd2;

endpackage

// File: rtl/instr_store_if.sv
// AXI4-Lite host port of the instruction store (byte addresses, WIDTH-bit data).
interface instr_store_if #(
  parameter int ADDR_W = 9,
  parameter int WIDTH  = 32
);
  logic [ADDR_W+1:0] AWADDR;
  logic              AWVALID;
  logic              AWREADY;
  logic [WIDTH-1:0]  WDATA;
  logic              WVALID;
  logic              WREADY;
  logic [1:0]        BRESP;
  logic              BVALID;
  logic              BREADY;
  logic [ADDR_W+1:0] ARADDR;
  logic              ARVALID;
  logic              ARREADY;
  logic [WIDTH-1:0]  RDATA;
  logic [1:0]        RRESP;
  logic              RVALID;
  logic              RREADY;

  modport slave (
    input  AWADDR, AWVALID, WDATA, WVALID, BREADY, ARADDR, ARVALID, RREADY,
    output AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
  );

  modport master (
    output AWADDR, AWVALID, WDATA, WVALID, BREADY, ARADDR, ARVALID, RREADY,
    input  AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
  );
endinterface

// File: rtl/instr_store_ram.sv
// Dual-port synchronous RAM: port A write/read, port B read-only, read-before-write.
// Storage is not reset; only the output registers are, and they update only on a read enable.
module instr_store_ram #(
  parameter int DEPTH  = 512,
  parameter int WIDTH  = 32,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we_a,
  input  logic              re_a,
  input  logic [ADDR_W-1:0] addr_a,
  input  logic [WIDTH-1:0]  din_a,
  output logic [WIDTH-1:0]  dout_a,
  input  logic              re_b,
  input  logic [ADDR_W-1:0] addr_b,
  output logic [WIDTH-1:0]  dout_b
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] dout_a_q, dout_b_q;

  always_ff @(posedge clk) begin
    if (we_a) mem[addr_a] <= din_a;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout_a_q <= '0;
      dout_b_q <= '0;
    end else begin
      if (re_a) dout_a_q <= mem[addr_a];
      if (re_b) dout_b_q <= mem[addr_b];
    end
  end

  assign dout_a = dout_a_q;
  assign dout_b = dout_b_q;
endmodule

// File: rtl/instr_store.sv
// Instruction store: AXI4-Lite load/readback, 1-cycle fetch port, program-length tracking.
// state    | meaning
// W_IDLE   | collecting AW and W beats in any order
// W_COMMIT | address/LOCK checked, array written when legal
// W_RESP   | BVALID held until BREADY
// R_IDLE   | ARREADY high unless a write commits this cycle
// R_READ   | port A read (waits while a write owns port A)
// R_RESP   | RVALID held until RREADY
module instr_store
  import instr_store_pkg::*;
#(
  parameter int DEPTH  = 512,
  parameter int WIDTH  = 32,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              CLK,
  input  logic              RSTN,
  instr_store_if.slave      axi,
  input  logic              LOCK,
  input  logic              CLEAR,
  input  logic              FETCH_EN,
  input  logic [ADDR_W-1:0] PC_AXI,
  output logic [WIDTH-1:0]  INSTR_AXI,
  output logic              INSTR_VALID,
  output logic [ADDR_W:0]   INSTR_COUNT
);
  logic [1:0]        w_state_q, w_state_d, r_state_q, r_state_d;
  logic              aw_held_q, aw_held_d, w_held_q, w_held_d;
  logic [ADDR_W+1:0] awaddr_q, awaddr_d, araddr_q, araddr_d;
  logic [WIDTH-1:0]  wdata_q, wdata_d;
  logic [1:0]        bresp_q, bresp_d, rresp_q, rresp_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              fetch_valid_q, fetch_valid_d, fetch_stop_q, fetch_stop_d;
  logic [ADDR_W-1:0] w_idx, r_idx, ram_addr_a;
  logic              w_err, r_err, committing, commit_ok, ar_ready, ram_re_a, fetch_stop;
  logic [WIDTH-1:0]  ram_dout_a, ram_dout_b;

  assign w_idx      = awaddr_q[ADDR_W+1:2];
  assign r_idx      = araddr_q[ADDR_W+1:2];
  assign w_err      = (awaddr_q[1:0] != 2'b00) || (int'(w_idx) >= DEPTH) || LOCK;
  assign r_err      = (araddr_q[1:0] != 2'b00) || (int'(r_idx) >= DEPTH);
  assign committing = (w_state_q == W_COMMIT);
  assign commit_ok  = committing && !w_err;
  assign ar_ready   = (r_state_q == R_IDLE) && !committing;
  assign ram_re_a   = (r_state_q == R_READ) && !committing && !r_err;
  assign ram_addr_a = committing ? w_idx : r_idx;
  assign fetch_stop = ({1'b0, PC_AXI} >= count_q);

  always_comb begin
    w_state_d = w_state_q;
    aw_held_d = aw_held_q;
    w_held_d  = w_held_q;
    awaddr_d  = awaddr_q;
    wdata_d   = wdata_q;
    bresp_d   = bresp_q;
    case (w_state_q)
      W_IDLE: begin
        if (axi.AWVALID && !aw_held_q) begin
          aw_held_d = 1'b1;
          awaddr_d  = axi.AWADDR;
        end
        if (axi.WVALID && !w_held_q) begin
          w_held_d = 1'b1;
          wdata_d  = axi.WDATA;
        end
        if (aw_held_d && w_held_d) begin
          w_state_d = W_COMMIT;
          aw_held_d = 1'b0;
          w_held_d  = 1'b0;
        end
      end
      W_COMMIT: begin
        bresp_d   = w_err ? RESP_SLVERR : RESP_OKAY;
        w_state_d = W_RESP;
      end
      W_RESP:  if (axi.BREADY) w_state_d = W_IDLE;
      default: w_state_d = W_IDLE;
    endcase
  end

  always_comb begin
    r_state_d = r_state_q;
    araddr_d  = araddr_q;
    rresp_d   = rresp_q;
    case (r_state_q)
      R_IDLE: begin
        if (axi.ARVALID && ar_ready) begin
          araddr_d  = axi.ARADDR;
          r_state_d = R_READ;
        end
      end
      R_READ: begin
        if (!committing) begin
          rresp_d   = r_err ? RESP_SLVERR : RESP_OKAY;
          r_state_d = R_RESP;
        end
      end
      R_RESP:  if (axi.RREADY) r_state_d = R_IDLE;
      default: r_state_d = R_IDLE;
    endcase
  end

  // CLEAR is applied before a same-cycle commit extends the program.
  always_comb begin
    count_d = CLEAR ? '0 : count_q;
    if (commit_ok && ({1'b0, w_idx} >= count_d)) count_d = {1'b0, w_idx} + (ADDR_W+1)'(1);
    fetch_valid_d = FETCH_EN;
    fetch_stop_d  = FETCH_EN ? fetch_stop : fetch_stop_q;
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      w_state_q     <= W_IDLE;
      r_state_q     <= R_IDLE;
      aw_held_q     <= 1'b0;
      w_held_q      <= 1'b0;
      awaddr_q      <= '0;
      araddr_q      <= '0;
      wdata_q       <= '0;
      bresp_q       <= RESP_OKAY;
      rresp_q       <= RESP_OKAY;
      count_q       <= '0;
      fetch_valid_q <= 1'b0;
      fetch_stop_q  <= 1'b0;
    end else begin
      w_state_q     <= w_state_d;
      r_state_q     <= r_state_d;
      aw_held_q     <= aw_held_d;
      w_held_q      <= w_held_d;
      awaddr_q      <= awaddr_d;
      araddr_q      <= araddr_d;
      wdata_q       <= wdata_d;
      bresp_q       <= bresp_d;
      rresp_q       <= rresp_d;
      count_q       <= count_d;
      fetch_valid_q <= fetch_valid_d;
      fetch_stop_q  <= fetch_stop_d;
    end
  end

  instr_store_ram #(.DEPTH(DEPTH), .WIDTH(WIDTH), .ADDR_W(ADDR_W)) u_ram (
    .clk    (CLK),
    .rst_n  (RSTN),
    .we_a   (commit_ok),
    .re_a   (ram_re_a),
    .addr_a (ram_addr_a),
    .din_a  (wdata_q),
    .dout_a (ram_dout_a),
    .re_b   (FETCH_EN && !fetch_stop),
    .addr_b (PC_AXI),
    .dout_b (ram_dout_b)
  );

  assign axi.AWREADY = (w_state_q == W_IDLE) && !aw_held_q;
  assign axi.WREADY  = (w_state_q == W_IDLE) && !w_held_q;
  assign axi.BVALID  = (w_state_q == W_RESP);
  assign axi.BRESP   = bresp_q;
  assign axi.ARREADY = ar_ready;
  assign axi.RVALID  = (r_state_q == R_RESP);
  assign axi.RRESP   = rresp_q;
  assign axi.RDATA   = ((r_state_q == R_RESP) && (rresp_q == RESP_OKAY)) ? ram_dout_a : '0;

  assign INSTR_AXI   = fetch_stop_q ? WIDTH'(STOP_INSTR) : ram_dout_b;
  assign INSTR_VALID = fetch_valid_q;
  assign INSTR_COUNT = count_q;
endmodule

// File: tb/tb_instr_store.sv
// Scoreboard bench for instr_store; DEPTH=1000 so out-of-range byte addresses fit the AXI address width.
module tb_instr_store;
  import instr_store_pkg::*;

  localparam int DEPTH  = 1000;
  localparam int WIDTH  = 32;
  localparam int ADDR_W = 10;
  localparam int AW     = ADDR_W + 2;

  logic              CLK = 1'b0;
  logic              RSTN = 1'b0;
  logic              LOCK = 1'b0;
  logic              CLEAR = 1'b0;
  logic              FETCH_EN = 1'b0;
  logic [ADDR_W-1:0] PC = '0;
  logic [WIDTH-1:0]  INSTR_AXI;
  logic              INSTR_VALID;
  logic [ADDR_W:0]   INSTR_COUNT;

  int n_tests = 0;
  int n_fail  = 0;

  logic [1:0]  exp_b [$];
  logic [33:0] exp_r [$];
  logic [31:0] exp_f [$];

  instr_store_if #(.ADDR_W(ADDR_W), .WIDTH(WIDTH)) bus ();

  instr_store #(.DEPTH(DEPTH), .WIDTH(WIDTH), .ADDR_W(ADDR_W)) dut (
    .CLK         (CLK),
    .RSTN        (RSTN),
    .axi         (bus),
    .LOCK        (LOCK),
    .CLEAR       (CLEAR),
    .FETCH_EN    (FETCH_EN),
    .PC_AXI      (PC),
    .INSTR_AXI   (INSTR_AXI),
    .INSTR_VALID (INSTR_VALID),
    .INSTR_COUNT (INSTR_COUNT)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] word_val(input int i);
    return 32'hC0DE_0000 + 32'(i) * 32'h0000_0101;
  endfunction

  // Monitor: pops the scoreboard whenever the DUT completes a response.
  always @(negedge CLK) begin
    if (RSTN) begin
      if (bus.BVALID && bus.BREADY) begin
        if (exp_b.size() == 0) chk("b_unexpected", 32'(bus.BRESP), 32'hFFFF_FFFF);
        else chk("bresp", 32'(bus.BRESP), 32'(exp_b.pop_front()));
      end
      if (bus.RVALID && bus.RREADY) begin
        if (exp_r.size() == 0) chk("r_unexpected", bus.RDATA, 32'hFFFF_FFFF);
        else begin
          logic [33:0] e;
          e = exp_r.pop_front();
          chk("rdata", bus.RDATA, e[31:0]);
          chk("rresp", 32'(bus.RRESP), 32'(e[33:32]));
        end
      end
      if (INSTR_VALID) begin
        if (exp_f.size() == 0) chk("f_unexpected", INSTR_AXI, 32'hFFFF_FFFF);
        else chk("instr", INSTR_AXI, exp_f.pop_front());
      end
    end
  end

  task automatic wait_b(output int lat);
    bit hs = 0;
    lat = 0;
    while (!hs && lat < 50) begin
      @(negedge CLK);
      hs = bus.BVALID && bus.BREADY;
      lat++;
      @(posedge CLK); #1;
    end
    if (!hs) chk("b_timeout", 32'(lat), 32'(0));
  endtask

  task automatic axi_write(input logic [AW-1:0] a, input logic [31:0] d,
                           input logic [1:0] er, input bit clr);
    bit aw_d = 0, w_d = 0;
    int cyc = 0, lat;
    exp_b.push_back(er);
    bus.AWADDR = a; bus.AWVALID = 1'b1;
    bus.WDATA  = d; bus.WVALID  = 1'b1;
    while (!(aw_d && w_d) && cyc < 50) begin
      @(negedge CLK);
      if (bus.AWVALID && bus.AWREADY) aw_d = 1;
      if (bus.WVALID && bus.WREADY) w_d = 1;
      @(posedge CLK); #1;
      if (aw_d) bus.AWVALID = 1'b0;
      if (w_d) bus.WVALID = 1'b0;
      cyc++;
    end
    if (!(aw_d && w_d)) chk("aw_w_timeout", 32'(cyc), 32'(0));
    if (clr) begin
      CLEAR = 1'b1; @(posedge CLK); #1; CLEAR = 1'b0;
    end
    wait_b(lat);
    if (!clr) chk("wr_latency", 32'(lat), 32'(2));
  endtask

  task automatic axi_read(input logic [AW-1:0] a, input logic [31:0] d, input logic [1:0] er);
    bit hs = 0;
    int cyc = 0;
    exp_r.push_back({er, d});
    bus.ARADDR = a; bus.ARVALID = 1'b1;
    while (!hs && cyc < 50) begin
      @(negedge CLK);
      hs = bus.ARVALID && bus.ARREADY;
      @(posedge CLK); #1;
      if (hs) bus.ARVALID = 1'b0;
      cyc++;
    end
    if (!hs) chk("ar_timeout", 32'(cyc), 32'(0));
    @(negedge CLK);
    chk("rvalid_early", 32'(bus.RVALID), 32'(0));
    @(posedge CLK); #1;
    hs = 0; cyc = 0;
    while (!hs && cyc < 50) begin
      @(negedge CLK);
      hs = bus.RVALID && bus.RREADY;
      cyc++;
      @(posedge CLK); #1;
    end
    chk("rd_latency", 32'(cyc), 32'(1));
  endtask

  task automatic fetch(input int pc, input logic [31:0] e);
    exp_f.push_back(e);
    FETCH_EN = 1'b1; PC = ADDR_W'(pc);
    @(posedge CLK); #1;
    FETCH_EN = 1'b0;
    @(negedge CLK);
    chk("fetch_valid", 32'(INSTR_VALID), 32'(1));
    @(posedge CLK); #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_awready"}, 32'(bus.AWREADY), 32'(1));
    chk({tag, "_wready"},  32'(bus.WREADY),  32'(1));
    chk({tag, "_arready"}, 32'(bus.ARREADY), 32'(1));
    chk({tag, "_bvalid"},  32'(bus.BVALID),  32'(0));
    chk({tag, "_rvalid"},  32'(bus.RVALID),  32'(0));
    chk({tag, "_bresp"},   32'(bus.BRESP),   32'(0));
    chk({tag, "_rresp"},   32'(bus.RRESP),   32'(0));
    chk({tag, "_rdata"},   bus.RDATA,        32'(0));
    chk({tag, "_instr"},   INSTR_AXI,        32'(0));
    chk({tag, "_ivalid"},  32'(INSTR_VALID), 32'(0));
    chk({tag, "_count"},   32'(INSTR_COUNT), 32'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.AWADDR = '0; bus.AWVALID = 1'b0; bus.WDATA = '0; bus.WVALID = 1'b0;
    bus.BREADY = 1'b1; bus.ARADDR = '0; bus.ARVALID = 1'b0; bus.RREADY = 1'b1;
    repeat (3) @(negedge CLK);
    check_reset_outputs("rst");
    @(posedge CLK); #1; RSTN = 1'b1;
    @(posedge CLK); #1;

    // Load a 17-word program, then fetch it back-to-back.
    for (int i = 0; i < 17; i++) axi_write(AW'(i * 4), word_val(i), RESP_OKAY, 0);
    chk("count_17", 32'(INSTR_COUNT), 32'(17));
    for (int i = 0; i < 17; i++) begin
      exp_f.push_back(word_val(i));
      FETCH_EN = 1'b1; PC = ADDR_W'(i);
      @(posedge CLK); #1;
    end
    FETCH_EN = 1'b0;
    @(posedge CLK); #1;
    fetch(17, STOP_INSTR);

    // W three cycles ahead of AW, B stalled for four cycles.
    bus.BREADY = 1'b0;
    exp_b.push_back(RESP_OKAY);
    bus.WDATA = 32'hDEAD_BEEF; bus.WVALID = 1'b1;
    @(posedge CLK); #1; bus.WVALID = 1'b0;
    repeat (2) begin @(posedge CLK); #1; end
    bus.AWADDR = AW'(12'h008); bus.AWVALID = 1'b1;
    @(posedge CLK); #1; bus.AWVALID = 1'b0;
    @(negedge CLK);
    chk("bvalid_early", 32'(bus.BVALID), 32'(0));
    for (int k = 0; k < 4; k++) begin
      @(negedge CLK);
      chk("bvalid_hold", 32'(bus.BVALID), 32'(1));
      chk("bresp_hold", 32'(bus.BRESP), 32'(RESP_OKAY));
    end
    @(posedge CLK); #1; bus.BREADY = 1'b1;
    begin int lat; wait_b(lat); end
    axi_read(AW'(12'h008), 32'hDEAD_BEEF, RESP_OKAY);
    chk("count_after_b", 32'(INSTR_COUNT), 32'(17));

    // LOCK rejects host writes but not reads.
    LOCK = 1'b1;
    axi_write(AW'(12'h00C), 32'h5555_AAAA, RESP_SLVERR, 0);
    axi_read(AW'(12'h00C), word_val(3), RESP_OKAY);
    LOCK = 1'b0;
    chk("count_locked", 32'(INSTR_COUNT), 32'(17));
    fetch(3, word_val(3));

    // Misaligned / out-of-range accesses.
    axi_write(AW'(12'h802), 32'h1111_1111, RESP_SLVERR, 0);
    axi_write(AW'(DEPTH * 4), 32'h2222_2222, RESP_SLVERR, 0);
    axi_read(AW'(DEPTH * 4), 32'h0, RESP_SLVERR);
    chk("count_bad_addr", 32'(INSTR_COUNT), 32'(17));

    // CLEAR together with a commit, then CLEAR alone.
    axi_write(AW'(5 * 4), 32'h0505_5A5A, RESP_OKAY, 1);
    chk("count_clear_commit", 32'(INSTR_COUNT), 32'(6));
    fetch(5, 32'h0505_5A5A);
    fetch(6, STOP_INSTR);
    CLEAR = 1'b1; @(posedge CLK); #1; CLEAR = 1'b0;
    chk("count_clear", 32'(INSTR_COUNT), 32'(0));
    fetch(0, STOP_INSTR);
    fetch(5, STOP_INSTR);

    // Reset between the AW and W handshakes.
    bus.AWADDR = '0; bus.AWVALID = 1'b1;
    @(posedge CLK); #1; bus.AWVALID = 1'b0;
    RSTN = 1'b0;
    @(negedge CLK);
    check_reset_outputs("mid_rst");
    @(posedge CLK); #1; RSTN = 1'b1;
    repeat (2) begin
      @(negedge CLK);
      chk("mid_rst_no_b", 32'(bus.BVALID), 32'(0));
    end
    @(posedge CLK); #1;
    axi_read(AW'(0), word_val(0), RESP_OKAY);
    axi_write(AW'(0), 32'h7777_0000, RESP_OKAY, 0);
    chk("count_after_rst", 32'(INSTR_COUNT), 32'(1));
    fetch(0, 32'h7777_0000);
    axi_read(AW'(12'h010), word_val(4), RESP_OKAY);

    repeat (3) @(posedge CLK);
    chk("sb_drain", 32'(exp_b.size() + exp_r.size() + exp_f.size()), 32'(0));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
